uart_prg_loader: RTL and testbench
==================================

Name: uart_prg_loader

Overview:
- Upstream feeder of main memory. Receives a framed program image on rxd.
- Assembles 12-bit instruction words, writes them sequentially into main memory from address 0.
- Holds the CPU (cpu_hold) until a complete, checksum-valid image is loaded.
- Sits between the rxd pin and the main memory write port. Bit timing uses the same clock_enable tick as uart_tx.

Parameters:
- CLKS_PER_BIT, 8, ce ticks per UART bit; must be even and >= 4.
- MEM_DEPTH, 255, maximum number of words accepted.
- ADDR_W, 12, width of mem_addr.
- SYNC_BYTE, 8'hA5, header byte that opens a load.

Ports:
- clk  in  1  system clock
- reset  in  1  reset
- ce  in  1  bit-timing clock enable, one clk cycle wide
- rxd  in  1  asynchronous serial input; idle high
- mem_we  out  1  one-cycle write strobe to main memory
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  12  write data
- cpu_hold  out  1  1 = CPU must not leave reset/FETCH
- load_done  out  1  sticky; image loaded and checksum OK
- load_error  out  1  sticky until next SYNC_BYTE; last load failed
- rx_frame_err  out  1  one-cycle pulse on a bad stop bit

Behaviour:
Interface: reset reset, synchronous, active-high; clock clk.

Reset values:
- mem_we=0, mem_addr=0, mem_wdata=0.
- cpu_hold=1, load_done=0, load_error=0, rx_frame_err=0.
- Both FSMs go to IDLE; checksum, count and index are cleared.
- Reset mid-load abandons the load. No further writes occur.

Receiver (sub-module):
- rxd passes through a 2-FF synchronizer, reset to 1.
- RX FSM states: IDLE, START, DATA, STOP. All state advance happens only on ce.
- IDLE -> START on a synchronized 0.
- START: at CLKS_PER_BIT/2 ticks, re-sample. If the line is 1, it was a glitch; return to IDLE. Otherwise go to DATA.
- DATA: 8 samples, each CLKS_PER_BIT ticks apart, LSB first.
- STOP: sample after CLKS_PER_BIT ticks.
  - Stop=1: byte_valid pulses for one clk with the byte.
  - Stop=0: rx_frame_err pulses and the byte is discarded.
  - Both cases return to IDLE.

Loader FSM (advances on byte_valid, or on a frame error where noted):
- IDLE: ignores all bytes except SYNC_BYTE. On SYNC_BYTE: load_error<=0, checksum<=0, go to COUNT.
- COUNT: N = byte.
  - N > MEM_DEPTH -> ERROR.
  - N = 0 -> CHECK.
  - Otherwise index<=0, go to HIGH.
- HIGH: byte[7:6] must be 00, else ERROR. Latch word[11:6]=byte[5:0]. checksum ^= byte. Go to LOW.
- LOW: word[5:0]=byte[5:0]; byte[7:6] must be 00, else ERROR. checksum ^= byte.
  - Next clk: mem_we=1 for exactly one cycle, mem_addr=index, mem_wdata=word.
  - Then index+1. If index+1 == N go to CHECK, else HIGH.
- CHECK: if byte == checksum, go to DONE; else ERROR.
- DONE: load_done=1, cpu_hold=0. Every later byte is ignored until reset.
- ERROR: load_error=1, cpu_hold stays 1, go to IDLE. Memory contents written before the error are left in place.
- rx_frame_err in any state other than IDLE or DONE -> ERROR.

Latency and boundaries:
- mem_we asserts 1 clk after byte_valid of the LOW byte.
- Address wraps never; N <= MEM_DEPTH is guaranteed by the COUNT check.
- A SYNC_BYTE value received inside the payload is treated as data, not as a restart.

Decomposition:
- Package uart_pkg holds the RX state enum (rx_state_t), the loader state enum (ldr_state_t: IDLE, COUNT, HIGH, LOW, CHECK, DONE, ERROR) and the SYNC_BYTE constant.
- Sub-module uart_rx contains the synchronizer and RX FSM. Outputs: byte_valid, byte_data, frame_err.
- The loader FSM sits in uart_prg_loader.

Test Plan:
- Send A5, 02, 01, 2A, 3F, 00, checksum 14 (XOR of 01, 2A, 3F, 00) -> two mem_we pulses (addr0=0x06A, addr1=0xFC0), then load_done=1, cpu_hold=0.
- Send A5, 00, 00 -> no mem_we, load_done=1.
- Send A5, 01, 05, 07, checksum FF -> addr0=0x147 written, then load_error=1, cpu_hold=1. A following valid image clears load_error and sets load_done.
- Send A5, 01, 45 (bit7:6=01) -> ERROR immediately, no mem_we.
- Send A5, 02, then a byte with stop bit 0 -> rx_frame_err pulse, load_error=1.
- Send A5, 01, 01, then assert reset for 1 clk, then send 2A -> no mem_we, cpu_hold=1, FSM in IDLE. A 1/2-bit low glitch on rxd produces no byte_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types, constants and checksum helpers for the UART program loader.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_COUNT = 3'd1,
    LD_HIGH  = 3'd2,
    LD_LOW   = 3'd3,
    LD_CHECK = 3'd4,
    LD_DONE  = 3'd5,
    LD_ERROR = 3'd6
  } ldr_state_t;

  // Header byte that opens a program load.
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Running XOR checksum over payload bytes.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

  // Payload bytes carry six data bits; the two top bits must be clear.
  function automatic logic payload_ok(input logic [7:0] data);
    return (data[7:6] == 2'b00);
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART byte receiver: 2-FF synchronizer plus mid-bit sampling FSM.
// All bit timing advances only on the ce tick.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] TICK_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TICK_ZERO = CNT_W'(0);

  logic [1:0]       sync_r;
  logic             rx_s;
  rx_state_t        state_r, state_nx;
  logic [CNT_W-1:0] tick_r, tick_nx;
  logic [2:0]       bit_r, bit_nx;
  logic [7:0]       shift_r, shift_nx;
  logic             valid_r, valid_nx;
  logic             ferr_r, ferr_nx;

  assign rx_s       = sync_r[1];
  assign byte_valid = valid_r;
  assign byte_data  = shift_r;
  assign frame_err  = ferr_r;

  // Bring the asynchronous line into the clk domain; idle level is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rxd};
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= RX_IDLE;
      tick_r  <= TICK_ZERO;
      bit_r   <= 3'd0;
      shift_r <= 8'd0;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      tick_r  <= tick_nx;
      bit_r   <= bit_nx;
      shift_r <= shift_nx;
      valid_r <= valid_nx;
      ferr_r  <= ferr_nx;
    end
  end

  // Next-state logic: start detect, half-bit glitch check, 8 data samples, stop check.
  always_comb begin
    state_nx = state_r;
    tick_nx  = tick_r;
    bit_nx   = bit_r;
    shift_nx = shift_r;
    valid_nx = 1'b0;
    ferr_nx  = 1'b0;
    case (state_r)
      RX_IDLE: begin
        if (ce && !rx_s) begin
          state_nx = RX_START;
          tick_nx  = TICK_ZERO;
        end else begin
          state_nx = RX_IDLE;
        end
      end
      RX_START: begin
        if (ce) begin
          if (tick_r == HALF_LAST) begin
            tick_nx = TICK_ZERO;
            bit_nx  = 3'd0;
            if (rx_s) begin
              state_nx = RX_IDLE;
            end else begin
              state_nx = RX_DATA;
            end
          end else begin
            tick_nx = tick_r + TICK_ONE;
          end
        end else begin
          tick_nx = tick_r;
        end
      end
      RX_DATA: begin
        if (ce) begin
          if (tick_r == FULL_LAST) begin
            tick_nx  = TICK_ZERO;
            shift_nx = {rx_s, shift_r[7:1]};
            if (bit_r == 3'd7) begin
              state_nx = RX_STOP;
            end else begin
              bit_nx = bit_r + 3'd1;
            end
          end else begin
            tick_nx = tick_r + TICK_ONE;
          end
        end else begin
          tick_nx = tick_r;
        end
      end
      RX_STOP: begin
        if (ce) begin
          if (tick_r == FULL_LAST) begin
            tick_nx  = TICK_ZERO;
            state_nx = RX_IDLE;
            if (rx_s) begin
              valid_nx = 1'b1;
            end else begin
              ferr_nx = 1'b1;
            end
          end else begin
            tick_nx = tick_r + TICK_ONE;
          end
        end else begin
          tick_nx = tick_r;
        end
      end
      default: begin
        state_nx = RX_IDLE;
        tick_nx  = TICK_ZERO;
      end
    endcase
  end

endmodule

// File: rtl/uart_prg_loader.sv
// Serial program loader: receives a framed image, writes 12-bit words to
// main memory from address 0 and releases the CPU once the checksum matches.
module uart_prg_loader
  import uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 8,
  parameter int         MEM_DEPTH    = 255,
  parameter int         ADDR_W       = 12,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              rxd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [11:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic              rx_frame_err
);

  logic        byte_valid_s;
  logic [7:0]  byte_data_s;
  logic        frame_err_s;

  ldr_state_t        state_r, state_nx;
  logic [7:0]        count_r, count_nx;
  logic [7:0]        index_r, index_nx;
  logic [7:0]        csum_r, csum_nx;
  logic [5:0]        word_hi_r, word_hi_nx;
  logic              we_r, we_nx;
  logic [ADDR_W-1:0] addr_r, addr_nx;
  logic [11:0]       wdata_r, wdata_nx;
  logic              done_r, done_nx;
  logic              error_r, error_nx;
  logic              hold_r, hold_nx;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .rxd       (rxd),
    .byte_valid(byte_valid_s),
    .byte_data (byte_data_s),
    .frame_err (frame_err_s)
  );

  assign mem_we       = we_r;
  assign mem_addr     = addr_r;
  assign mem_wdata    = wdata_r;
  assign cpu_hold     = hold_r;
  assign load_done    = done_r;
  assign load_error   = error_r;
  assign rx_frame_err = frame_err_s;

  // Loader state, image bookkeeping and registered memory/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= LD_IDLE;
      count_r   <= 8'd0;
      index_r   <= 8'd0;
      csum_r    <= 8'd0;
      word_hi_r <= 6'd0;
      we_r      <= 1'b0;
      addr_r    <= {ADDR_W{1'b0}};
      wdata_r   <= 12'd0;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
      hold_r    <= 1'b1;
    end else begin
      state_r   <= state_nx;
      count_r   <= count_nx;
      index_r   <= index_nx;
      csum_r    <= csum_nx;
      word_hi_r <= word_hi_nx;
      we_r      <= we_nx;
      addr_r    <= addr_nx;
      wdata_r   <= wdata_nx;
      done_r    <= done_nx;
      error_r   <= error_nx;
      hold_r    <= hold_nx;
    end
  end

  // Image parser: header, count, high/low word halves, checksum, outcome.
  always_comb begin
    state_nx   = state_r;
    count_nx   = count_r;
    index_nx   = index_r;
    csum_nx    = csum_r;
    word_hi_nx = word_hi_r;
    we_nx      = 1'b0;
    addr_nx    = addr_r;
    wdata_nx   = wdata_r;
    done_nx    = done_r;
    error_nx   = error_r;
    hold_nx    = hold_r;
    // A broken frame inside a load aborts it; idle/done lines ignore noise.
    if (frame_err_s && (state_r != LD_IDLE) && (state_r != LD_DONE) && (state_r != LD_ERROR)) begin
      state_nx = LD_ERROR;
    end else begin
      case (state_r)
        LD_IDLE: begin
          if (byte_valid_s && (byte_data_s == SYNC_BYTE)) begin
            error_nx = 1'b0;
            csum_nx  = 8'd0;
            state_nx = LD_COUNT;
          end else begin
            state_nx = LD_IDLE;
          end
        end
        LD_COUNT: begin
          if (byte_valid_s) begin
            count_nx = byte_data_s;
            if (int'(byte_data_s) > MEM_DEPTH) begin
              state_nx = LD_ERROR;
            end else if (byte_data_s == 8'd0) begin
              state_nx = LD_CHECK;
            end else begin
              index_nx = 8'd0;
              state_nx = LD_HIGH;
            end
          end else begin
            state_nx = LD_COUNT;
          end
        end
        LD_HIGH: begin
          if (byte_valid_s) begin
            if (payload_ok(byte_data_s)) begin
              word_hi_nx = byte_data_s[5:0];
              csum_nx    = csum_step(csum_r, byte_data_s);
              state_nx   = LD_LOW;
            end else begin
              state_nx = LD_ERROR;
            end
          end else begin
            state_nx = LD_HIGH;
          end
        end
        LD_LOW: begin
          if (byte_valid_s) begin
            if (payload_ok(byte_data_s)) begin
              csum_nx  = csum_step(csum_r, byte_data_s);
              we_nx    = 1'b1;
              addr_nx  = ADDR_W'(index_r);
              wdata_nx = {word_hi_r, byte_data_s[5:0]};
              index_nx = index_r + 8'd1;
              if ((index_r + 8'd1) == count_r) begin
                state_nx = LD_CHECK;
              end else begin
                state_nx = LD_HIGH;
              end
            end else begin
              state_nx = LD_ERROR;
            end
          end else begin
            state_nx = LD_LOW;
          end
        end
        LD_CHECK: begin
          if (byte_valid_s) begin
            if (byte_data_s == csum_r) begin
              done_nx  = 1'b1;
              hold_nx  = 1'b0;
              state_nx = LD_DONE;
            end else begin
              state_nx = LD_ERROR;
            end
          end else begin
            state_nx = LD_CHECK;
          end
        end
        LD_DONE: begin
          state_nx = LD_DONE;
        end
        LD_ERROR: begin
          error_nx = 1'b1;
          hold_nx  = 1'b1;
          state_nx = LD_IDLE;
        end
        default: begin
          state_nx = LD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_prg_loader.sv
// Self-checking bench for uart_prg_loader: directed image scenarios plus
// randomized images checked against a byte-stream reference model.
module tb_uart_prg_loader;
  import uart_pkg::*;

  localparam int CPB      = 8;
  localparam int CE_DIV   = 3;
  localparam int BIT_CLKS = CPB * CE_DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic        rxd = 1'b1;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [11:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  logic        rx_frame_err;

  int n_run = 0;
  int n_fail = 0;

  uart_prg_loader #(
    .CLKS_PER_BIT(CPB),
    .MEM_DEPTH   (255),
    .ADDR_W      (12),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ce          (ce),
    .rxd         (rxd),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_hold    (cpu_hold),
    .load_done   (load_done),
    .load_error  (load_error),
    .rx_frame_err(rx_frame_err)
  );

  always #5 clk = ~clk;

  // One-clk-wide ce every CE_DIV clocks.
  int ce_cnt = 0;
  always @(negedge clk) begin
    ce_cnt = (ce_cnt + 1) % CE_DIV;
    ce = (ce_cnt == 0);
  end

  // Monitor: collect memory writes, write latency after the last received byte, pulses.
  int cyc = 0;
  int last_bv = 0;
  int bv_cnt = 0;
  int ferr_cnt = 0;
  logic [11:0] wa_q[$];
  logic [11:0] wd_q[$];
  int          lat_q[$];
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (dut.u_rx.byte_valid) begin
      bv_cnt = bv_cnt + 1;
      last_bv = cyc;
    end
    if (mem_we) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
      lat_q.push_back(cyc - last_bv);
    end
    if (rx_frame_err) ferr_cnt = ferr_cnt + 1;
  end

  logic [7:0] stim[$];

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    lat_q.delete();
    ferr_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    clear_mon();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int gap_bits);
    rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (BIT_CLKS) @(negedge clk);
    rxd = 1'b1;
    repeat (gap_bits * BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_list(input logic [7:0] q[$], input bit random_gap);
    foreach (q[i]) send_byte(q[i], 1'b1, random_gap ? int'($urandom_range(0, 1)) : 1);
    repeat (2 * BIT_CLKS) @(negedge clk);
  endtask

  // Reference model: scan the byte stream for loads and predict writes and status.
  task automatic model(input logic [7:0] b[$], output logic [11:0] ea[$], output logic [11:0] ed[$],
                       output bit done, output bit err);
    int p;
    int sz;
    int n;
    bit fail;
    logic [7:0] hi, lo, cs;
    ea = {};
    ed = {};
    done = 1'b0;
    err = 1'b0;
    p = 0;
    sz = b.size();
    while (p < sz && !done) begin
      if (b[p] != 8'hA5) begin
        p++;
        continue;
      end
      p++;
      err = 1'b0;
      if (p >= sz) return;
      n = int'(b[p]);
      p++;
      cs = 8'd0;
      fail = 1'b0;
      for (int k = 0; k < n; k++) begin
        if (p >= sz) return;
        hi = b[p];
        p++;
        if (hi[7:6] != 2'b00) begin fail = 1'b1; break; end
        if (p >= sz) return;
        lo = b[p];
        p++;
        if (lo[7:6] != 2'b00) begin fail = 1'b1; break; end
        ea.push_back(12'(k));
        ed.push_back({hi[5:0], lo[5:0]});
        cs = cs ^ hi ^ lo;
      end
      if (!fail) begin
        if (p >= sz) return;
        if (b[p] == cs) done = 1'b1;
        else fail = 1'b1;
        p++;
      end
      if (fail) err = 1'b1;
    end
  endtask

  task automatic build_image(input int n, output logic [7:0] q[$]);
    logic [11:0] w;
    logic [7:0] cs;
    q = {};
    cs = 8'd0;
    q.push_back(8'hA5);
    q.push_back(8'(n));
    for (int k = 0; k < n; k++) begin
      w = 12'($urandom);
      q.push_back({2'b00, w[11:6]});
      q.push_back({2'b00, w[5:0]});
      cs = cs ^ {2'b00, w[11:6]} ^ {2'b00, w[5:0]};
    end
    q.push_back(cs);
  endtask

  task automatic test_reset();
    do_reset();
    repeat (4) @(negedge clk);
    n_run++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b expected 0", mem_we); end
    n_run++; if (mem_addr !== 12'h000) begin n_fail++; $display("FAIL reset_addr: got %0h expected 0", mem_addr); end
    n_run++; if (mem_wdata !== 12'h000) begin n_fail++; $display("FAIL reset_wdata: got %0h expected 0", mem_wdata); end
    n_run++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_hold: got %0b expected 1", cpu_hold); end
    n_run++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", load_done); end
    n_run++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %0b expected 0", load_error); end
    n_run++; if (rx_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %0b expected 0", rx_frame_err); end
  endtask

  task automatic test_basic_image();
    do_reset();
    stim = {8'hA5, 8'h02, 8'h01, 8'h2A, 8'h3F, 8'h00, 8'h14};
    send_list(stim, 1'b0);
    n_run++; if (wa_q.size() !== 2) begin n_fail++; $display("FAIL basic_wr_count: got %0d expected 2", wa_q.size()); end
    else begin
      n_run++; if (wa_q[0] !== 12'h000 || wd_q[0] !== 12'h06A) begin n_fail++; $display("FAIL basic_wr0: got %0h=%0h expected 0=06a", wa_q[0], wd_q[0]); end
      n_run++; if (wa_q[1] !== 12'h001 || wd_q[1] !== 12'hFC0) begin n_fail++; $display("FAIL basic_wr1: got %0h=%0h expected 1=fc0", wa_q[1], wd_q[1]); end
      n_run++; if (lat_q[0] !== 1 || lat_q[1] !== 1) begin n_fail++; $display("FAIL basic_latency: got %0d,%0d expected 1,1", lat_q[0], lat_q[1]); end
    end
    n_run++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %0b expected 1", load_done); end
    n_run++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL basic_hold: got %0b expected 0", cpu_hold); end
    n_run++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL basic_error: got %0b expected 0", load_error); end
    // Once done, further images are ignored until reset.
    stim = {8'hA5, 8'h01, 8'h01, 8'h01, 8'h00};
    send_list(stim, 1'b0);
    n_run++; if (wa_q.size() !== 2 || load_done !== 1'b1) begin n_fail++; $display("FAIL done_ignores: got %0d writes done=%0b expected 2 writes done=1", wa_q.size(), load_done); end
  endtask

  task automatic test_empty_image();
    do_reset();
    stim = {8'hA5, 8'h00, 8'h00};
    send_list(stim, 1'b0);
    n_run++; if (wa_q.size() !== 0) begin n_fail++; $display("FAIL empty_writes: got %0d expected 0", wa_q.size()); end
    n_run++; if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin n_fail++; $display("FAIL empty_done: got done=%0b hold=%0b expected done=1 hold=0", load_done, cpu_hold); end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    stim = {8'hA5, 8'h01, 8'h05, 8'h07, 8'hFF};
    send_list(stim, 1'b0);
    n_run++; if (wa_q.size() !== 1 || wd_q[0] !== 12'h147 || wa_q[0] !== 12'h000) begin n_fail++; $display("FAIL badcs_write: got %0d writes expected one 0=147", wa_q.size()); end
    n_run++; if (load_error !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0) begin n_fail++; $display("FAIL badcs_status: got err=%0b hold=%0b done=%0b expected 1 1 0", load_error, cpu_hold, load_done); end
    stim = {8'hA5, 8'h02, 8'h01, 8'h2A, 8'h3F, 8'h00, 8'h14};
    send_list(stim, 1'b0);
    n_run++; if (load_error !== 1'b0 || load_done !== 1'b1 || cpu_hold !== 1'b0) begin n_fail++; $display("FAIL recover_status: got err=%0b done=%0b hold=%0b expected 0 1 0", load_error, load_done, cpu_hold); end
    n_run++; if (wa_q.size() !== 3 || wd_q[1] !== 12'h06A || wd_q[2] !== 12'hFC0 || wa_q[2] !== 12'h001) begin n_fail++; $display("FAIL recover_writes: got %0d writes expected 3", wa_q.size()); end
  endtask

  task automatic test_bad_high_and_sync_payload();
    do_reset();
    stim = {8'hA5, 8'h01, 8'h45};
    send_list(stim, 1'b0);
    n_run++; if (load_error !== 1'b1 || wa_q.size() !== 0) begin n_fail++; $display("FAIL badhigh: got err=%0b writes=%0d expected 1 0", load_error, wa_q.size()); end
    // The header value inside the payload is data, not a restart.
    do_reset();
    stim = {8'hA5, 8'h02, 8'hA5, 8'h01, 8'h01, 8'h02, 8'h03};
    send_list(stim, 1'b1);
    n_run++; if (load_error !== 1'b1 || load_done !== 1'b0 || wa_q.size() !== 0) begin n_fail++; $display("FAIL sync_in_payload: got err=%0b done=%0b writes=%0d expected 1 0 0", load_error, load_done, wa_q.size()); end
  endtask

  task automatic test_frame_err();
    do_reset();
    stim = {8'hA5, 8'h02};
    send_list(stim, 1'b0);
    send_byte(8'h11, 1'b0, 3);
    n_run++; if (ferr_cnt !== 1) begin n_fail++; $display("FAIL frame_pulse: got %0d pulses expected 1", ferr_cnt); end
    n_run++; if (load_error !== 1'b1 || cpu_hold !== 1'b1 || wa_q.size() !== 0) begin n_fail++; $display("FAIL frame_status: got err=%0b hold=%0b writes=%0d expected 1 1 0", load_error, cpu_hold, wa_q.size()); end
  endtask

  task automatic test_reset_midload_and_glitch();
    int bv0;
    int f0;
    do_reset();
    stim = {8'hA5, 8'h01, 8'h01};
    send_list(stim, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send_byte(8'h2A, 1'b1, 2);
    n_run++; if (wa_q.size() !== 0 || cpu_hold !== 1'b1 || load_done !== 1'b0) begin n_fail++; $display("FAIL midreset: got writes=%0d hold=%0b done=%0b expected 0 1 0", wa_q.size(), cpu_hold, load_done); end
    n_run++; if (dut.state_r !== LD_IDLE) begin n_fail++; $display("FAIL midreset_state: got %0d expected %0d", dut.state_r, LD_IDLE); end
    // Half-bit low pulse must not produce a byte.
    bv0 = bv_cnt;
    f0 = ferr_cnt;
    rxd = 1'b0;
    repeat ((CPB / 2) * CE_DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (12 * BIT_CLKS) @(negedge clk);
    n_run++; if (bv_cnt !== bv0 || ferr_cnt !== f0) begin n_fail++; $display("FAIL glitch: got bytes=%0d ferr=%0d expected %0d %0d", bv_cnt - bv0, ferr_cnt - f0, 0, 0); end
    stim = {8'hA5, 8'h01, 8'h01, 8'h2A, 8'h2B};
    send_list(stim, 1'b0);
    n_run++; if (load_done !== 1'b1 || wa_q.size() !== 1 || wd_q[0] !== 12'h06A) begin n_fail++; $display("FAIL midreset_recover: got done=%0b writes=%0d expected 1 1", load_done, wa_q.size()); end
  endtask

  task automatic test_random_images();
    logic [7:0] s[$];
    logic [7:0] img[$];
    logic [11:0] ea[$];
    logic [11:0] ed[$];
    bit edone, eerr;
    int mode, n, j;
    logic [7:0] tmp;
    bit wr_ok;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      s = {};
      mode = int'($urandom_range(0, 3));
      n = int'($urandom_range(1, 4));
      if (mode == 3) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) s.push_back(8'($urandom_range(0, 8'hA4)));
      end
      build_image(n, img);
      if (mode == 1) img[img.size() - 1] = img[img.size() - 1] ^ 8'($urandom_range(1, 255));
      if (mode == 2) begin
        j = 2 + int'($urandom_range(0, 2 * n - 1));
        tmp = 8'($urandom_range(1, 3));
        img[j] = img[j] | {tmp[1:0], 6'd0};
      end
      foreach (img[i]) s.push_back(img[i]);
      if ((mode == 1 || mode == 2) && $urandom_range(0, 1) == 1) begin
        build_image(int'($urandom_range(1, 3)), img);
        foreach (img[i]) s.push_back(img[i]);
      end
      send_list(s, 1'b1);
      model(s, ea, ed, edone, eerr);
      wr_ok = (wa_q.size() == ea.size());
      if (wr_ok) foreach (ea[i]) if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) wr_ok = 1'b0;
      n_run++; if (!wr_ok) begin n_fail++; $display("FAIL rand_writes it%0d mode%0d: got %0d writes expected %0d (or data differs)", it, mode, wa_q.size(), ea.size()); end
      n_run++; if (load_done !== edone || load_error !== eerr || cpu_hold !== !edone) begin n_fail++; $display("FAIL rand_status it%0d mode%0d: got done=%0b err=%0b hold=%0b expected %0b %0b %0b", it, mode, load_done, load_error, cpu_hold, edone, eerr, !edone); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_image();
    test_empty_image();
    test_bad_checksum();
    test_bad_high_and_sync_payload();
    test_frame_err();
    test_reset_midload_and_glitch();
    test_random_images();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
